// File: rtl/wptr_level_ctrl.sv
// wptr_level_ctrl: write-domain FIFO pointer, level and status controller.
// Optional sticky overflow flag is compiled in when WPTR_OVF_EN is defined.
// Status is computed against the synchronised read pointer, so occupancy
// may be over-reported but is never under-reported.
module wptr_level_ctrl #(
    parameter int ADDR_SIZE = 4
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 winc,
    input  logic [ADDR_SIZE:0]   wq2_rptr,
    input  logic [ADDR_SIZE:0]   afull_thresh,
    input  logic                 wovf_clr,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic [ADDR_SIZE:0]   wptr,
    output logic                 wfull,
    output logic                 walmost_full,
    output logic [ADDR_SIZE:0]   wlevel,
    output logic                 wovf
);
    logic [ADDR_SIZE:0] r_wbin;
    logic [ADDR_SIZE:0] r_wptr;
    logic [ADDR_SIZE:0] r_wlevel;
    logic               r_wfull;
    logic               r_walmost_full;
    logic               w_wr_ok;
    logic [ADDR_SIZE:0] w_wbin_next;
    logic [ADDR_SIZE:0] w_wgray_next;
    logic [ADDR_SIZE:0] w_rbin;
    logic [ADDR_SIZE:0] w_level_next;
    logic               w_full_next;
    logic               w_afull_next;

    // A write is dropped while full, so pointers never pass the read side.
    assign w_wr_ok      = winc & ~r_wfull;
    assign w_wbin_next  = r_wbin + {{ADDR_SIZE{1'b0}}, w_wr_ok};
    assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);

    // Each binary bit of the read pointer is the XOR of all Gray bits at or above it.
    for (genvar g = 0; g <= ADDR_SIZE; g++) begin : g_rbin
        assign w_rbin[g] = ^wq2_rptr[ADDR_SIZE:g];
    end

    // Modulo subtraction gives the right level across pointer wrap.
    assign w_level_next = w_wbin_next - w_rbin;
    assign w_full_next  = w_wgray_next == {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]};
    assign w_afull_next = w_level_next >= afull_thresh;

    // Pointer and status registers refresh every edge so read progress frees space without a write.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wlevel       <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
        end else begin
            r_wbin         <= w_wbin_next;
            r_wptr         <= w_wgray_next;
            r_wlevel       <= w_level_next;
            r_wfull        <= w_full_next;
            r_walmost_full <= w_afull_next;
        end
    end

`ifdef WPTR_OVF_EN
    logic r_wovf;

    // Sticky overflow: a new overflow wins over a simultaneous clear.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n)
            r_wovf <= 1'b0;
        else
            r_wovf <= (winc & r_wfull) | (r_wovf & ~wovf_clr);
    end

    assign wovf = r_wovf;
`else
    logic w_unused_ovf_clr;

    assign w_unused_ovf_clr = wovf_clr;
    assign wovf             = 1'b0;
`endif

    assign waddr        = r_wbin[ADDR_SIZE-1:0];
    assign wptr         = r_wptr;
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wlevel       = r_wlevel;
endmodule

// File: tb/tb_wptr_level_ctrl.sv
// tb_wptr_level_ctrl: directed self-checking bench for wptr_level_ctrl (ADDR_SIZE=4).
module tb_wptr_level_ctrl;
    logic       wclk = 1'b0;
    logic       wrst_n = 1'b0;
    logic       winc = 1'b0;
    logic [4:0] wq2_rptr = '0;
    logic [4:0] afull_thresh = 5'd12;
    logic       wovf_clr = 1'b0;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       wovf;
    int         checks = 0;
    int         failures = 0;

`ifdef WPTR_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    wptr_level_ctrl #(.ADDR_SIZE(4)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
        .afull_thresh(afull_thresh), .wovf_clr(wovf_clr), .waddr(waddr),
        .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full),
        .wlevel(wlevel), .wovf(wovf)
    );

    always #5 wclk = ~wclk;

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic step;
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge wclk);
        wrst_n = 1'b0;
        winc = 1'b0;
        wovf_clr = 1'b0;
        wq2_rptr = '0;
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    task automatic test_reset;
        afull_thresh = 5'd12;
        do_reset();
        checks++;
        if ({waddr, wptr, wfull, walmost_full, wlevel, wovf} !== 17'd0) begin
            failures++;
            $display("FAIL reset_initial got=%h want=0", {waddr, wptr, wfull, walmost_full, wlevel, wovf});
        end
        winc = 1'b1;
        for (int k = 0; k < 9; k++) step();
        winc = 1'b0;
        checks++;
        if (wlevel !== 5'd9) begin
            failures++;
            $display("FAIL reset_prefill_level got=%0d want=9", wlevel);
        end
        #2 wrst_n = 1'b0;
        #1;
        checks++;
        if ({waddr, wptr, wfull, walmost_full, wlevel, wovf} !== 17'd0) begin
            failures++;
            $display("FAIL reset_async got=%h want=0", {waddr, wptr, wfull, walmost_full, wlevel, wovf});
        end
        @(negedge wclk);
        wrst_n = 1'b1;
        step();
        step();
        checks++;
        if ({waddr, wptr, wfull, walmost_full, wlevel, wovf} !== 17'd0) begin
            failures++;
            $display("FAIL reset_hold_idle got=%h want=0", {waddr, wptr, wfull, walmost_full, wlevel, wovf});
        end
    endtask

    task automatic test_fill;
        afull_thresh = 5'd12;
        do_reset();
        winc = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++;
            if (wlevel !== 5'(k) || walmost_full !== (k >= 12) || wfull !== (k == 16)) begin
                failures++;
                $display("FAIL fill_edge%0d got lvl=%0d af=%b f=%b want lvl=%0d af=%b f=%b",
                         k, wlevel, walmost_full, wfull, k, k >= 12, k == 16);
            end
        end
        winc = 1'b0;
        checks++;
        if (waddr !== 4'd0 || wptr !== 5'b11000 || wlevel !== 5'd16) begin
            failures++;
            $display("FAIL fill_final got addr=%0d ptr=%b lvl=%0d want addr=0 ptr=11000 lvl=16", waddr, wptr, wlevel);
        end
    endtask

    task automatic test_overflow;
        winc = 1'b1;
        step();
        winc = 1'b0;
        checks++;
        if ({waddr, wptr, wlevel, wfull, wovf} !== {4'd0, 5'b11000, 5'd16, 1'b1, OVF}) begin
            failures++;
            $display("FAIL ovf_set got addr=%0d ptr=%b lvl=%0d f=%b ovf=%b want 0 11000 16 1 %b",
                     waddr, wptr, wlevel, wfull, wovf, OVF);
        end
        step();
        checks++;
        if (wovf !== OVF || wptr !== 5'b11000) begin
            failures++;
            $display("FAIL ovf_sticky got ovf=%b ptr=%b want ovf=%b ptr=11000", wovf, wptr, OVF);
        end
        wovf_clr = 1'b1;
        step();
        checks++;
        if (wovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got=%b want=0", wovf);
        end
        winc = 1'b1;
        step();
        winc = 1'b0;
        wovf_clr = 1'b0;
        checks++;
        if (wovf !== OVF || wlevel !== 5'd16) begin
            failures++;
            $display("FAIL ovf_set_beats_clr got ovf=%b lvl=%0d want ovf=%b lvl=16", wovf, wlevel, OVF);
        end
        wovf_clr = 1'b1;
        step();
        wovf_clr = 1'b0;
        checks++;
        if (wovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear2 got=%b want=0", wovf);
        end
    endtask

    task automatic test_release;
        wq2_rptr = 5'b00110;
        step();
        checks++;
        if (wlevel !== 5'd12 || wfull !== 1'b0 || walmost_full !== 1'b1 || wptr !== 5'b11000) begin
            failures++;
            $display("FAIL release got lvl=%0d f=%b af=%b ptr=%b want 12 0 1 11000", wlevel, wfull, walmost_full, wptr);
        end
    endtask

    task automatic test_thresholds;
        afull_thresh = 5'd0;
        do_reset();
        step();
        checks++;
        if (walmost_full !== 1'b1 || wlevel !== 5'd0) begin
            failures++;
            $display("FAIL thresh0 got af=%b lvl=%0d want af=1 lvl=0", walmost_full, wlevel);
        end
        afull_thresh = 5'd17;
        do_reset();
        winc = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            checks++;
            if (walmost_full !== 1'b0) begin
                failures++;
                $display("FAIL thresh17_edge%0d got af=%b want 0", k, walmost_full);
            end
        end
        afull_thresh = 5'd16;
        do_reset();
        winc = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++;
            if (walmost_full !== (k == 16) || wfull !== (k == 16)) begin
                failures++;
                $display("FAIL thresh16_edge%0d got af=%b f=%b want %b", k, walmost_full, wfull, k == 16);
            end
        end
        winc = 1'b0;
    endtask

    task automatic test_wrap;
        logic [4:0] wb;
        bit seen_top;
        bit seen_zero;
        afull_thresh = 5'd12;
        do_reset();
        winc = 1'b1;
        for (int k = 0; k < 3; k++) step();
        wb = 5'd3;
        seen_top = 1'b0;
        seen_zero = 1'b0;
        for (int k = 0; k < 40; k++) begin
            wq2_rptr = gray(wb - 5'd2);
            wb = wb + 5'd1;
            step();
            checks++;
            if (wlevel !== 5'd3 || wfull !== 1'b0 || wptr !== gray(wb) || waddr !== wb[3:0]) begin
                failures++;
                $display("FAIL wrap_w%0d got lvl=%0d f=%b ptr=%b addr=%0d want lvl=3 f=0 ptr=%b addr=%0d",
                         k, wlevel, wfull, wptr, waddr, gray(wb), wb[3:0]);
            end
            if (wptr == 5'b10000) seen_top = 1'b1;
            if (seen_top && wptr == 5'd0) seen_zero = 1'b1;
        end
        winc = 1'b0;
        checks++;
        if (!(seen_top && seen_zero)) begin
            failures++;
            $display("FAIL wrap_passes got top=%b zero=%b want 1 1", seen_top, seen_zero);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_thresholds();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
